// File: rtl/clock_pkg.sv
// Shared types and defaults for the clock set-button controller.
// Holds the FSM state encoding, timing defaults and the tick-limit helper.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } set_state_e;

  localparam int unsigned HOLD_TICKS_DEF   = 8;
  localparam int unsigned REPEAT_TICKS_DEF = 2;
  localparam int unsigned TICK_CNT_W       = 8;

  // True when the tick being counted now is the lim-th one.
  function automatic logic limit_hit(
    input logic [TICK_CNT_W-1:0] cnt,
    input logic [TICK_CNT_W-1:0] lim
  );
    return ({1'b0, cnt} + 9'd1) >= {1'b0, lim};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: 2-flop synchronizer then tick-sampled debouncer.
// Ports: clk, rst (sync, active-high), tick, btn (raw) -> level (debounced).
module button_debounce (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level
);

  logic sync1;
  logic sync2;
  logic pend;

  // pend marks that the previous tick sample already differed from level;
  // a second differing sample in a row commits the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      pend  <= 1'b0;
      level <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (tick) begin
        if (sync2 != level) begin
          if (pend) begin
            level <= sync2;
            pend  <= 1'b0;
          end else begin
            pend  <= 1'b1;
          end
        end else begin
          pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Hours/minutes set-button controller with hold-to-auto-repeat stepping.
// Ports: clk, rst, tick, btn_hours, btn_minutes -> set_hours, set_minutes, set_stb.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_hours,
  input  logic btn_minutes,
  output logic set_hours,
  output logic set_minutes,
  output logic set_stb
);

  localparam logic [TICK_CNT_W-1:0] HOLD_LIM =
    TICK_CNT_W'(HOLD_TICKS);
  localparam logic [TICK_CNT_W-1:0] REPEAT_LIM =
    TICK_CNT_W'(REPEAT_TICKS);

  logic db_h;
  logic db_m;
  logic db_h_q;
  logic db_m_q;
  logic rise_h;
  logic rise_m;
  logic sel_h;
  logic sel_lvl;
  logic tick_hit;

  logic [TICK_CNT_W-1:0] tick_cnt;
  logic [TICK_CNT_W-1:0] lim;

  set_state_e state;

  button_debounce u_db_hours (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .btn   (btn_hours),
    .level (db_h)
  );

  button_debounce u_db_minutes (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .btn   (btn_minutes),
    .level (db_m)
  );

  assign rise_h   = db_h & ~db_h_q;
  assign rise_m   = db_m & ~db_m_q;
  assign sel_lvl  = sel_h ? db_h : db_m;
  assign lim      = (state == HOLD) ? HOLD_LIM : REPEAT_LIM;
  assign tick_hit = tick & limit_hit(tick_cnt, lim);

  // Only the selected button's level matters once armed; the other
  // button is ignored until we are back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel_h       <= 1'b0;
      tick_cnt    <= '0;
      db_h_q      <= 1'b0;
      db_m_q      <= 1'b0;
      set_hours   <= 1'b0;
      set_minutes <= 1'b0;
      set_stb     <= 1'b0;
    end else begin
      db_h_q  <= db_h;
      db_m_q  <= db_m;
      set_stb <= 1'b0;
      unique case (state)
        IDLE: begin
          tick_cnt    <= '0;
          set_hours   <= 1'b0;
          set_minutes <= 1'b0;
          if (rise_h) begin
            sel_h     <= 1'b1;
            set_hours <= 1'b1;
            state     <= ARM;
          end else if (rise_m) begin
            sel_h       <= 1'b0;
            set_minutes <= 1'b1;
            state       <= ARM;
          end
        end
        ARM: begin
          tick_cnt <= '0;
          if (!sel_lvl) begin
            set_hours   <= 1'b0;
            set_minutes <= 1'b0;
            state       <= IDLE;
          end else begin
            set_stb <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!sel_lvl) begin
            set_hours   <= 1'b0;
            set_minutes <= 1'b0;
            tick_cnt    <= '0;
            state       <= IDLE;
          end else if (tick_hit) begin
            // A limit tick landing on a strobe cycle waits for the next
            // tick so strobes can never run back to back.
            if (!set_stb) begin
              set_stb  <= 1'b1;
              tick_cnt <= '0;
              state    <= REPEAT;
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          set_hours   <= 1'b0;
          set_minutes <= 1'b0;
          tick_cnt    <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: timing, repeat counts, reset.
// Ends with a random press/release run that checks output invariants.
module tb_clock_set_controller;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic btn_hours;
  logic btn_minutes;
  logic set_hours;
  logic set_minutes;
  logic set_stb;

  int checks   = 0;
  int failures = 0;

  int stb_total = 0;
  int act_total = 0;
  int hrs_total = 0;
  int min_total = 0;

  logic prev_h   = 1'b0;
  logic prev_m   = 1'b0;
  logic prev_stb = 1'b0;

  int base_stb;
  int base_act;
  int base_hrs;
  int base_min;

  always #5 clk = ~clk;

  clock_set_controller #(
    .HOLD_TICKS   (8),
    .REPEAT_TICKS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .btn_hours   (btn_hours),
    .btn_minutes (btn_minutes),
    .set_hours   (set_hours),
    .set_minutes (set_minutes),
    .set_stb     (set_stb)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock step, sampled on the falling edge, with invariant checks.
  task automatic cyc();
    logic stb_ok;
    @(negedge clk);
    if (set_stb) stb_total++;
    if (set_hours) hrs_total++;
    if (set_minutes) min_total++;
    if (set_hours | set_minutes | set_stb) act_total++;
    check("inv_not_both", int'(set_hours & set_minutes), 0);
    stb_ok = !set_stb ||
             ((set_hours ^ set_minutes) &&
              ((set_hours && prev_h) || (set_minutes && prev_m)));
    check("inv_stb_sel", int'(stb_ok), 1);
    check("inv_stb_b2b", int'(set_stb & prev_stb), 0);
    prev_h   = set_hours;
    prev_m   = set_minutes;
    prev_stb = set_stb;
  endtask

  // Ends on the falling edge right after the tick's rising edge.
  task automatic tick_edge();
    cyc();
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_tick();
    tick_edge();
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic snap();
    base_stb = stb_total;
    base_act = act_total;
    base_hrs = hrs_total;
    base_min = min_total;
  endtask

  initial begin
    rst         = 1'b1;
    tick        = 1'b0;
    btn_hours   = 1'b0;
    btn_minutes = 1'b0;
    repeat (3) cyc();
    check("rst_set_hours", int'(set_hours), 0);
    check("rst_set_minutes", int'(set_minutes), 0);
    check("rst_set_stb", int'(set_stb), 0);
    rst = 1'b0;
    cyc();
    cyc();

    // Short hours press: exact ARM/stb timing, one strobe.
    snap();
    btn_hours = 1'b1;
    do_tick();
    tick_edge();
    check("t27_pre_arm", int'(set_hours), 0);
    cyc();
    check("t27_arm_hours", int'(set_hours), 1);
    check("t27_arm_nostb", int'(set_stb), 0);
    cyc();
    check("t27_arm_stb", int'(set_stb), 1);
    cyc();
    check("t27_stb_pulse", int'(set_stb), 0);
    do_tick();
    btn_hours = 1'b0;
    do_tick();
    tick_edge();
    check("t27_fall_held", int'(set_hours), 1);
    cyc();
    check("t27_fall_idle", int'(set_hours), 0);
    check("t27_fall_stb", int'(set_stb), 0);
    check("t27_stb_count", stb_total - base_stb, 1);
    check("t27_min_quiet", min_total - base_min, 0);
    ticks(2);

    // Long minutes hold: ARM strobe, hold strobe at tick 10, repeats.
    snap();
    btn_minutes = 1'b1;
    ticks(3);
    check("t28_arm_stb", stb_total - base_stb, 1);
    check("t28_minutes", int'(set_minutes), 1);
    ticks(6);
    check("t28_before_hold", stb_total - base_stb, 1);
    ticks(1);
    check("t28_hold_stb", stb_total - base_stb, 2);
    ticks(10);
    check("t28_total_stb", stb_total - base_stb, 7);
    check("t28_hours_quiet", hrs_total - base_hrs, 0);
    btn_minutes = 1'b0;
    ticks(3);
    check("t28_rel_minutes", int'(set_minutes), 0);
    check("t28_rel_stb", int'(set_stb), 0);
    ticks(2);

    // Simultaneous press: hours wins, minutes release ignored.
    snap();
    btn_hours   = 1'b1;
    btn_minutes = 1'b1;
    ticks(3);
    check("t29_hours", int'(set_hours), 1);
    check("t29_minutes", int'(set_minutes), 0);
    btn_minutes = 1'b0;
    ticks(3);
    check("t29_min_rel_h", int'(set_hours), 1);
    check("t29_min_rel_m", int'(set_minutes), 0);
    btn_hours = 1'b0;
    do_tick();
    tick_edge();
    check("t29_fall_held", int'(set_hours), 1);
    cyc();
    check("t29_fall_idle", int'(set_hours), 0);
    check("t29_stb_count", stb_total - base_stb, 1);
    check("t29_min_quiet", min_total - base_min, 0);
    ticks(2);

    // One-sample glitch must be filtered.
    snap();
    btn_hours = 1'b1;
    do_tick();
    btn_hours = 1'b0;
    ticks(4);
    check("t30_glitch_act", act_total - base_act, 0);

    // Reset in REPEAT with a tick on the reset cycle.
    btn_minutes = 1'b1;
    ticks(13);
    check("t31_repeat_m", int'(set_minutes), 1);
    snap();
    rst  = 1'b1;
    tick = 1'b1;
    cyc();
    rst  = 1'b0;
    tick = 1'b0;
    check("t31_rst_minutes", int'(set_minutes), 0);
    check("t31_rst_stb", int'(set_stb), 0);
    check("t31_rst_stbcnt", stb_total - base_stb, 0);
    do_tick();
    check("t31_tick1_m", int'(set_minutes), 0);
    tick_edge();
    check("t31_tick2_m", int'(set_minutes), 0);
    cyc();
    check("t31_rearm_m", int'(set_minutes), 1);
    check("t31_rearm_stb", stb_total - base_stb, 0);
    cyc();
    check("t31_rearm_pulse", int'(set_stb), 1);
    btn_minutes = 1'b0;
    ticks(4);
    check("t31_rel_m", int'(set_minutes), 0);

    // Random press/release run; invariants are checked in cyc().
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_hours = ~btn_hours;
      if ($urandom_range(0, 7) == 0) btn_minutes = ~btn_minutes;
      do_tick();
    end
    btn_hours   = 1'b0;
    btn_minutes = 1'b0;
    ticks(4);
    check("t32_end_hours", int'(set_hours), 0);
    check("t32_end_minutes", int'(set_minutes), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 8, ticks a button is held before auto-repeat starts (range 1..255).
REQ-002 SHALL have parameter REPEAT_TICKS, default 2, ticks between auto-repeat steps (range 1..255).
REQ-003 clk  input  1  system clock; the only clock, all state on its rising edge.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 tick  input  1  sample strobe, one clk wide, nominally 16 Hz.
REQ-006 btn_hours  input  1  raw hours-set button, asynchronous, active-high.
REQ-007 btn_minutes  input  1  raw minutes-set button, asynchronous, active-high.
REQ-008 set_hours  output  1  registered; selects hours-set mode in the time register.
REQ-009 set_minutes  output  1  registered; selects minutes-set mode in the time register.
REQ-010 set_stb  output  1  registered one-clk pulse; advance the selected field by one.

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer, then a debouncer sampling on tick: debounced level changes only after 2 consecutive equal tick samples differing from the current level.
REQ-012 FSM states SHALL be IDLE, ARM, HOLD, REPEAT.
REQ-013 IDLE: set_hours=set_minutes=0, set_stb=0; a rising debounced button at cycle N moves to ARM at N+1 with the matching set_* = 1.
REQ-014 Both debounced buttons rising in the same cycle SHALL select hours; minutes is ignored.
REQ-015 ARM: lasts exactly one cycle; set_stb=1 at N+2 (one cycle after set_* asserts); next state HOLD; tick counter cleared.
REQ-016 HOLD: counts ticks; after HOLD_TICKS ticks SHALL enter REPEAT with a set_stb pulse on the cycle after the HOLD_TICKS-th tick.
REQ-017 REPEAT: set_stb SHALL pulse one cycle after every REPEAT_TICKS-th tick; counter wraps to 0 on each pulse.
REQ-018 The non-selected button SHALL be ignored in ARM/HOLD/REPEAT, including its press and release.
REQ-019 Selected debounced button falling at cycle M (any non-IDLE state) SHALL give IDLE, set_*=0 and set_stb=0 at M+1; a pending stb is dropped.
REQ-020 set_hours and set_minutes SHALL never both be 1; set_stb SHALL be 1 only while exactly one set_* is 1 and was 1 the previous cycle.
REQ-021 set_stb SHALL never be high on two consecutive cycles.
REQ-022 Tick counter SHALL be 8 bits, saturating-free: cleared on ARM and on every repeat pulse.

Reset
REQ-023 rst SHALL force IDLE, all outputs 0, counters 0, synchronizer and debounced levels 0, overriding all other inputs that cycle.
REQ-024 rst asserted mid-REPEAT SHALL suppress any set_stb from the cycle after rst is sampled; after release a still-held button is seen as a new press only after re-debouncing (2 ticks).

Structure
REQ-025 State encoding and HOLD_TICKS/REPEAT_TICKS defaults SHALL live in shared package clock_pkg.
REQ-026 Synchronizer plus debouncer SHALL be a sub-module button_debounce, instantiated once per button.

Verification
REQ-027 Press btn_hours for 3 ticks, release -> set_hours high for duration, exactly one set_stb, set_minutes 0 throughout.
REQ-028 Hold btn_minutes 20 ticks, defaults -> 1 stb at ARM, 1 at tick 8 of HOLD, then one per 2 ticks: 7 stb total.
REQ-029 Both buttons rise same tick -> set_hours only; releasing btn_minutes first changes nothing; releasing btn_hours -> IDLE next cycle.
REQ-030 Single-tick glitch on btn_hours -> no output activity.
REQ-031 rst pulsed during REPEAT with button held -> outputs 0 next cycle; new ARM only after 2 ticks post-rst.
REQ-032 Random press/release stress over 10k ticks -> REQ-020/REQ-021 invariants hold every cycle.
